// File: rtl/nand_out_sampler_if.sv
// Valid/ready sample channel between nand_out_sampler (master) and its consumer (slave).
interface nand_out_sampler_if;
   logic sample_valid;
   logic sample_ready;
   logic sample_data;
   logic sample_err;

   modport master (
      output sample_valid,
      output sample_data,
      output sample_err,
      input  sample_ready
   );

   modport slave (
      input  sample_valid,
      input  sample_data,
      input  sample_err,
      output sample_ready
   );
endinterface

// File: rtl/nand_out_sampler.sv
// Synchronizes the raw NAND_2 output, waits for it to settle (or time out) and hands it over via valid/ready.
// Optional glitch/edge counter on edge_count is built only when NAND_SAMPLER_GLITCH_COUNT_EN is defined.
module nand_out_sampler #(
   parameter int SETTLE_CYCLES  = 4,
   parameter int TIMEOUT_CYCLES = 64,
   parameter int CNT_W          = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 gate_in,
   input  logic                 start,
   nand_out_sampler_if.master   smp,
   output logic                 busy,
   output logic [CNT_W-1:0]     edge_count
);

   localparam int ST_W = $clog2(SETTLE_CYCLES + 1);
   localparam int TM_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [ST_W-1:0] SETTLE_LAST = ST_W'(SETTLE_CYCLES - 1);
   localparam logic [TM_W-1:0] TMO_LAST    = TM_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, SETTLE, VALID} state_t;

   state_t          state;
   logic            sync1;
   logic            sync2;
   logic            prev;
   logic [ST_W-1:0] stable_cnt;
   logic [TM_W-1:0] tmo_cnt;
   logic            same;

   // gate_in is asynchronous; only sync2 may be used beyond this point
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         prev  <= 1'b0;
      end else begin
         sync1 <= gate_in;
         sync2 <= sync1;
         prev  <= sync2;
      end
   end

   assign same = (sync2 == prev);

`ifndef NAND_SAMPLER_GLITCH_COUNT_EN
   assign edge_count = '0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= IDLE;
         busy             <= 1'b0;
         smp.sample_valid <= 1'b0;
         smp.sample_data  <= 1'b0;
         smp.sample_err   <= 1'b0;
         stable_cnt       <= '0;
         tmo_cnt          <= '0;
`ifdef NAND_SAMPLER_GLITCH_COUNT_EN
         edge_count       <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state      <= SETTLE;
                  busy       <= 1'b1;
                  stable_cnt <= '0;
                  tmo_cnt    <= '0;
`ifdef NAND_SAMPLER_GLITCH_COUNT_EN
                  edge_count <= '0;
`endif
               end
            end
            SETTLE: begin
               tmo_cnt <= tmo_cnt + TM_W'(1);
               if (!same) begin
                  stable_cnt <= '0;
`ifdef NAND_SAMPLER_GLITCH_COUNT_EN
                  if (edge_count != '1)
                     edge_count <= edge_count + CNT_W'(1);
`endif
               end else begin
                  stable_cnt <= stable_cnt + ST_W'(1);
               end
               // A settle on the final timeout cycle takes priority over the timeout
               if (same && stable_cnt == SETTLE_LAST) begin
                  smp.sample_data  <= sync2;
                  smp.sample_err   <= 1'b0;
                  smp.sample_valid <= 1'b1;
                  state            <= VALID;
               end else if (tmo_cnt == TMO_LAST) begin
                  smp.sample_data  <= sync2;
                  smp.sample_err   <= 1'b1;
                  smp.sample_valid <= 1'b1;
                  state            <= VALID;
               end
            end
            VALID: begin
               if (smp.sample_ready) begin
                  smp.sample_valid <= 1'b0;
                  if (start) begin
                     state      <= SETTLE;
                     stable_cnt <= '0;
                     tmo_cnt    <= '0;
`ifdef NAND_SAMPLER_GLITCH_COUNT_EN
                     edge_count <= '0;
`endif
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end
            end
            default: begin
               state            <= IDLE;
               busy             <= 1'b0;
               smp.sample_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_nand_out_sampler.sv
// Scoreboard bench for nand_out_sampler: expected samples are queued at start and checked on the handshake.
module tb_nand_out_sampler;
   localparam int SETTLE_CYCLES  = 4;
   localparam int TIMEOUT_CYCLES = 64;
   localparam int CNT_W          = 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             gate_in;
   logic             start;
   logic             busy;
   logic [CNT_W-1:0] edge_count;

   nand_out_sampler_if smp();

   nand_out_sampler #(
      .SETTLE_CYCLES (SETTLE_CYCLES),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
      .CNT_W         (CNT_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .gate_in   (gate_in),
      .start     (start),
      .smp       (smp.master),
      .busy      (busy),
      .edge_count(edge_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic             data;
      logic             err;
      logic [CNT_W-1:0] edges;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, actual, expected);
      end
   endtask

   function automatic logic [CNT_W-1:0] expEdges(input int n);
`ifdef NAND_SAMPLER_GLITCH_COUNT_EN
      return CNT_W'(n);
`else
      return CNT_W'(n * 0);
`endif
   endfunction

   task automatic applyStimulus(input logic data, input logic err, input int edges);
      exp_t e;
      e.data  = data;
      e.err   = err;
      e.edges = expEdges(edges);
      exp_q.push_back(e);
      start = 1'b1;
   endtask

   // Toggles gate_in on negedges 1, 1+period, ... (count times) while waiting for valid
   task automatic waitValid(input int budget, input int period, input int count, output int cycles);
      int done;
      done   = 0;
      cycles = 0;
      while (smp.sample_valid !== 1'b1 && cycles < budget) begin
         @(negedge clk);
         cycles++;
         start = 1'b0;
         if (period > 0 && done < count && (cycles - 1) % period == 0) begin
            gate_in = ~gate_in;
            done++;
         end
      end
      checkOutput("valid_seen", smp.sample_valid, 1);
   endtask

   task automatic consume(input logic restart);
      exp_t e;
      checkOutput("queue_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() == 0) return;
      e = exp_q.pop_front();
      checkOutput("sample_data", smp.sample_data, e.data);
      checkOutput("sample_err", smp.sample_err, e.err);
      checkOutput("edge_count", edge_count, e.edges);
      smp.sample_ready = 1'b1;
      start            = restart;
      @(negedge clk);
      smp.sample_ready = 1'b0;
      start            = 1'b0;
      checkOutput("valid_drop", smp.sample_valid, 0);
      checkOutput("busy_after_accept", busy, restart);
      if (restart) checkOutput("edge_cleared", edge_count, 0);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish, observed running expected finished");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int   lat;
      int   n;
      logic g0;

      rst_n            = 1'b0;
      gate_in          = 1'b1;
      start            = 1'b1;
      smp.sample_ready = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("rst_valid", smp.sample_valid, 0);
      checkOutput("rst_data", smp.sample_data, 0);
      checkOutput("rst_err", smp.sample_err, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_edges", edge_count, 0);

      // Synchronizer restarts from 0 while gate_in=1, so one synchronized edge is seen
      applyStimulus(1'b1, 1'b0, 1);
      rst_n = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checkOutput("busy_first_clock", busy, 1);
      waitValid(100, 0, 0, lat);
      checkOutput("latency_after_reset", lat + 1, SETTLE_CYCLES + 3);
      consume(1'b0);

      smp.sample_ready = 1'b1;
      repeat (2) @(negedge clk);
      smp.sample_ready = 1'b0;
      checkOutput("idle_ready_busy", busy, 0);
      checkOutput("idle_ready_valid", smp.sample_valid, 0);

      $display("[TB] clean settle");
      applyStimulus(1'b1, 1'b0, 0);
      waitValid(100, 0, 0, lat);
      checkOutput("latency_clean", lat, SETTLE_CYCLES + 1);
      consume(1'b0);

      $display("[TB] glitch recovery");
      applyStimulus(1'b0, 1'b0, 3);
      waitValid(100, 3, 3, lat);
      checkOutput("latency_glitch", lat, 7 + 2 + SETTLE_CYCLES + 1);
      consume(1'b0);

      $display("[TB] timeout with backpressure");
      g0 = gate_in;
      n  = (TIMEOUT_CYCLES - 1) / 2;
      applyStimulus(g0 ^ n[0], 1'b1, n);
      waitValid(TIMEOUT_CYCLES + 20, 2, 1000, lat);
      checkOutput("latency_timeout", lat, TIMEOUT_CYCLES + 1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (i % 2 == 0) gate_in = ~gate_in;
         checkOutput("bp_valid", smp.sample_valid, 1);
         checkOutput("bp_data", smp.sample_data, exp_q[0].data);
      end
      repeat (3) @(negedge clk);
      checkOutput("bp_err_held", smp.sample_err, exp_q[0].err);
      applyStimulus(gate_in, 1'b0, 0);
      consume(1'b1);
      waitValid(100, 0, 0, lat);
      checkOutput("latency_restart", lat + 1, SETTLE_CYCLES + 1);
      consume(1'b0);

      $display("[TB] reset mid-settle");
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("midrst_valid", smp.sample_valid, 0);
      checkOutput("midrst_busy", busy, 0);
      checkOutput("midrst_data", smp.sample_data, 0);
      checkOutput("midrst_edges", edge_count, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      applyStimulus(gate_in, 1'b0, 0);
      waitValid(100, 0, 0, lat);
      checkOutput("latency_after_midrst", lat, SETTLE_CYCLES + 1);
      consume(1'b0);

      checkOutput("scoreboard_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end
endmodule

// File: doc/nand_out_sampler.md
Name: nand_out_sampler

Overview:
- Synchronous capture stage directly downstream of the switch-level NAND_2 cell; consumes the gate output W, which is asynchronous and glitchy during propagation delays.
- Synchronizes W into the clock domain and waits until the value has been stable for a programmable number of cycles.
- Delivers the settled value over a valid/ready handshake; flags a timeout if the value never settles.
- Used by gate-level test harnesses to read settled results of the transistor-level gates.

Parameters:
- SETTLE_CYCLES, 4, consecutive identical synchronized samples required to declare the value settled (>=1).
- TIMEOUT_CYCLES, 64, maximum cycles spent in SETTLE before a timeout (> SETTLE_CYCLES).
- CNT_W, 8, width of the glitch/edge counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- gate_in  input  1  raw NAND output W; asynchronous to clk.
- start  input  1  request a new settled sample; sampled only in IDLE.
- sample_ready  input  1  consumer accepts the sample.
- sample_valid  output  1  sample_data and sample_err are valid.
- sample_data  output  1  settled gate value.
- sample_err  output  1  1 = timeout; sample_data holds the last synchronized value.
- busy  output  1  high in SETTLE and VALID.
- edge_count  output  CNT_W  synchronized transitions seen during the current SETTLE phase.

Behaviour:
- Reset (rst_n=0, asynchronous) sets:
  - sample_valid=0, sample_data=0, sample_err=0, busy=0, edge_count=0.
  - Synchronizer flops to 0, both counters to 0, state IDLE.
- Synchronizer:
  - Two flops, sync1 then sync2; sync2 is the only signal used internally.
  - Input-to-sync2 latency is 2 cycles.
  - prev register holds the previous sync2 value for edge detection.
- States: IDLE, SETTLE, VALID.
- IDLE:
  - busy=0, sample_valid=0.
  - start=1 -> SETTLE next cycle, with stable_cnt=0, tmo_cnt=0, edge_count=0.
- SETTLE:
  - busy=1; tmo_cnt increments every cycle.
  - If sync2 != prev: stable_cnt <= 0; edge_count increments, saturating at 2^CNT_W-1 (no wrap).
  - Else: stable_cnt increments.
  - When stable_cnt reaches SETTLE_CYCLES-1 with sync2==prev (SETTLE_CYCLES identical cycles): latch sample_data <= sync2, sample_err <= 0, go to VALID.
  - Else if tmo_cnt reaches TIMEOUT_CYCLES-1: latch sample_data <= sync2, sample_err <= 1, go to VALID.
  - If settle and timeout occur in the same cycle, settle wins (sample_err=0).
  - start is ignored in SETTLE.
- VALID:
  - sample_valid=1, busy=1; sample_data and sample_err are held stable while sample_ready=0.
  - sample_ready=1 -> IDLE next cycle and sample_valid drops.
  - start=1 together with sample_ready=1 -> SETTLE directly, counters cleared, no IDLE cycle.
  - start without sample_ready is ignored.
  - edge_count holds its final value until the next SETTLE entry.
- Minimum start-to-valid latency, with gate_in already stable: SETTLE_CYCLES+1 cycles (1 cycle entering SETTLE, plus SETTLE_CYCLES counting).
- Reset mid-operation: immediate return to reset values. No partial sample is ever presented.
- sample_ready is ignored outside VALID.

Optional Feature:
- Macro: NAND_SAMPLER_GLITCH_COUNT_EN.
- Defined: edge_count behaves as specified above.
- Not defined:
  - The edge counter logic is not built and edge_count is tied to 0.
  - stable_cnt still restarts on every transition.
  - All other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 with gate_in=1 and start=1 -> all outputs 0, busy=0. Release rst_n -> FSM enters SETTLE on the first clock with start=1.
- Clean settle: gate_in=1 held steady, defaults, pulse start -> sample_valid=1 exactly 5 cycles after start, sample_data=1, sample_err=0, edge_count=0.
- Glitch recovery: after start, toggle gate_in 0/1/0 on 3 separate cycles (each held >=2 cycles), then hold at 0 -> sample_data=0, sample_err=0, edge_count=3 with macro defined (0 without). Valid appears SETTLE_CYCLES cycles after the last synchronized edge.
- Timeout: toggle gate_in every 2 cycles continuously, TIMEOUT_CYCLES=64 -> sample_valid=1 with sample_err=1, 64 cycles after SETTLE entry.
- Backpressure: hold sample_ready=0 for 10 cycles in VALID while toggling gate_in -> sample_data unchanged and sample_valid stays 1. Assert sample_ready together with start -> next cycle in SETTLE with edge_count=0.
- Reset mid-SETTLE: drop rst_n after 2 stable cycles -> outputs 0 immediately. After release, a new start needs the full 5 cycles to reach sample_valid.
